// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//            Optional even parity when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  input  logic                          err_clr_i,
  output logic                          irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3
  } state_t;
`endif

  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  state_t         state_q;
  logic [CW-1:0]  clk_cnt_q;
  logic [2:0]     cnt_q;
  logic [7:0]     shift_q;
  logic           push_q;
  logic [7:0]     push_data_q;
  logic           ferr_set_q;
  logic           par_err;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    level_q, level_d;
  logic           overrun_q, frame_err_q;
  logic           pop, full, push_ok, ovr_set;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ferr_set_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            cnt_q     <= '0;
          end
        end
        S_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s2_q, shift_q[7:1]};
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            par_err_q <= rx_s2_q ^ (^shift_q);
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
            if (rx_s2_q && !par_err) begin
              push_q      <= 1'b1;
              push_data_q <= shift_q;
            end else begin
              ferr_set_q  <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop     = rx_valid_o & rx_ready_i;
  assign full    = (level_q == FULL_LVL);
  // A same-cycle pop frees the slot, so a push into a full FIFO is still taken.
  assign push_ok = push_q & (~full | pop);
  assign ovr_set = push_q & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      overrun_q   <= ovr_set | (overrun_q & ~err_clr_i);
      frame_err_q <= ferr_set_q | (frame_err_q & ~err_clr_i);
    end
  end

  assign rx_data_o   = mem_q[rd_ptr_q];
  assign rx_valid_o  = (level_q != '0);
  assign rx_level_o  = level_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;
  assign irq_o       = rx_valid_o | overrun_q | frame_err_q;

endmodule

`default_nettype wire
